// File: rtl/gain_shift_saturate.sv
// gain_shift_saturate
// I/Q amplitude correction behind the CORDIC core. Each sample is multiplied
// by an unsigned Q0.GW gain, shifted left, optionally rounded half-up, and
// saturated to OW bits. There are three pipeline stages, all gated by ce:
//   S1  full-precision product.  Shift and round mode are captured here with
//       the sample.
//   S2  shift, add the rounding constant, and floor-divide by 2^GW.
//   S3  clamp to OW bits, produce per-sample flags, and update the sticky
//       flag and the event counter.
// The same X/Y datapath is generated once per channel.
module gain_shift_saturate #(
  parameter int IW   = 12,
  parameter int OW   = 12,
  parameter int GW   = 32,
  parameter int SW   = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            in_valid,
  input  logic [IW-1:0]   x_in,
  input  logic [IW-1:0]   y_in,
  input  logic [GW-1:0]   gain,
  input  logic [SW-1:0]   shift,
  input  logic            round_en,
  input  logic            sat_clr,
  output logic            out_valid,
  output logic [OW-1:0]   x_out,
  output logic [OW-1:0]   y_out,
  output logic            sat_x,
  output logic            sat_y,
  output logic            sat_sticky,
  output logic [CNTW-1:0] sat_count
);

  // Channel 0 is X and channel 1 is Y.
  localparam int NCH = 2;
  // Width of the signed product of the sample and the zero-extended gain.
  localparam int PW  = IW + GW + 1;
  // Width of the shifted and rounded value. It is sized so that it cannot
  // overflow at the maximum shift.
  localparam int TW  = IW + GW + (1 << SW) + 1;
  // Width of the value left after the fractional bits are dropped.
  localparam int VW  = TW - GW;

  // Half an LSB of the output, in product units.
  localparam logic [TW-1:0] RND_HALF = {{(TW-GW){1'b0}}, 1'b1, {(GW-1){1'b0}}};
  localparam logic [OW-1:0] OUT_MAX  = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] OUT_MIN  = {1'b1, {(OW-1){1'b0}}};

  logic [NCH-1:0][IW-1:0] smp_in;
  logic [NCH-1:0][OW-1:0] out_all;
  logic [NCH-1:0]         sat_all;
  logic [NCH-1:0]         ovf_all;

  assign smp_in = {y_in, x_in};

  // ---------------------------------------------------------------------
  // Valid bits and per-sample controls that travel with the data.
  // ---------------------------------------------------------------------
  logic          v1_q, v1_d;
  logic          v2_q, v2_d;
  logic          v3_q, v3_d;
  logic [SW-1:0] shift1_q, shift1_d;
  logic          round1_q, round1_d;

  // Advance valids and captured controls only on ce. Otherwise they hold.
  always_comb begin
    v1_d     = v1_q;
    v2_d     = v2_q;
    v3_d     = v3_q;
    shift1_d = shift1_q;
    round1_d = round1_q;
    if (ce) begin
      v1_d     = in_valid;
      v2_d     = v1_q;
      v3_d     = v2_q;
      shift1_d = shift;
      round1_d = round_en;
    end
  end

  // Control pipeline registers. An asynchronous reset discards in-flight samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      shift1_q <= '0;
      round1_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      shift1_q <= shift1_d;
      round1_q <= round1_d;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel arithmetic.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : gen_ch
      logic signed [PW-1:0] p_q, p_d;
      logic signed [VW-1:0] v_q, v_d;
      logic [OW-1:0]        o_q, o_d;
      logic                 sat_q, sat_d;
      logic signed [TW-1:0] t_shl;
      logic [TW-1:0]        t_sum;
      logic                 ovf;
      // Only the carry out of the fractional bits matters. The fraction
      // itself is discarded.
      logic                 unused_t_frac;

      // S1: signed sample times gain, with the gain treated as a non-negative value.
      always_comb begin
        p_d = p_q;
        if (ce) begin
          p_d = $signed({{(PW-IW){smp_in[gi][IW-1]}}, smp_in[gi]}) *
                $signed({{(PW-GW){1'b0}}, gain});
        end
      end

      // S2: sign-extend, shift left, add the half-LSB when rounding, then
      // keep the integer part. Taking the upper bits of a two's-complement
      // value is a floor.
      always_comb begin
        t_shl = {{(TW-PW){p_q[PW-1]}}, p_q} <<< shift1_q;
        t_sum = t_shl + (round1_q ? RND_HALF : '0);
        v_d   = v_q;
        if (ce) begin
          v_d = t_sum[TW-1:GW];
        end
      end

      assign unused_t_frac = ^t_sum[GW-1:0];

      // The value fits in OW bits only if every bit from the OW-1 sign
      // position upward is the same.
      assign ovf = ~((&v_q[VW-1:OW-1]) | ~(|v_q[VW-1:OW-1]));

      // S3: clamp to the OW-bit range. The flag is qualified by valid so
      // that bubbles never report saturation.
      always_comb begin
        o_d   = o_q;
        sat_d = sat_q;
        if (ce) begin
          if (ovf) begin
            o_d = v_q[VW-1] ? OUT_MIN : OUT_MAX;
          end else begin
            o_d = v_q[OW-1:0];
          end
          sat_d = v2_q & ovf;
        end
      end

      // Per-channel data registers for all three stages.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_q   <= '0;
          v_q   <= '0;
          o_q   <= '0;
          sat_q <= 1'b0;
        end else begin
          p_q   <= p_d;
          v_q   <= v_d;
          o_q   <= o_d;
          sat_q <= sat_d;
        end
      end

      assign out_all[gi] = o_q;
      assign sat_all[gi] = sat_q;
      assign ovf_all[gi] = ovf;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Sticky flag and saturation event counter.
  // ---------------------------------------------------------------------
  logic            sticky_q, sticky_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            sat_evt;

  // One event per valid sample entering S3 that clamps on either channel.
  assign sat_evt = ce & v2_q & (|ovf_all);

  // A clear wins over a same-cycle event and works even while ce is low.
  // The counter stops at its maximum value instead of wrapping.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (sat_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (sat_evt) begin
      sticky_d = 1'b1;
      if (!(&cnt_q)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = v3_q;
  assign x_out      = out_all[0];
  assign y_out      = out_all[1];
  assign sat_x      = sat_all[0];
  assign sat_y      = sat_all[1];
  assign sat_sticky = sticky_q;
  assign sat_count  = cnt_q;

endmodule

// File: tb/tb_gain_shift_saturate.sv
// tb_gain_shift_saturate
// Randomised and directed bench for gain_shift_saturate. The reference model
// computes each output with 64-bit integer arithmetic: multiply, shift, add
// the half, floor, then clamp. A second instance with CNTW=4 exercises the
// counter limit.
module tb_gain_shift_saturate;
  localparam int IW = 12;
  localparam int OW = 12;
  localparam int GW = 32;
  localparam int SW = 3;

  typedef struct packed {
    logic signed [OW-1:0] x;
    logic signed [OW-1:0] y;
    logic                 sx;
    logic                 sy;
  } res_t;

  typedef struct {
    res_t r;
    int   idx;
  } ent_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 ce = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [IW-1:0] x_in = '0;
  logic signed [IW-1:0] y_in = '0;
  logic [GW-1:0]        gain = '0;
  logic [SW-1:0]        shift = '0;
  logic                 round_en = 1'b0;
  logic                 sat_clr = 1'b0;

  logic                 out_valid, sat_x, sat_y, sat_sticky;
  logic signed [OW-1:0] x_out, y_out;
  logic [15:0]          sat_count;
  logic                 out_valid_4, sat_x_4, sat_y_4, sat_sticky_4;
  logic signed [OW-1:0] x_out_4, y_out_4;
  logic [3:0]           sat_count_4;

  int n_checks = 0;
  int n_pass   = 0;
  int ce_cnt   = 0;
  int m_cnt16  = 0;
  int m_cnt4   = 0;
  bit m_sticky = 0;

  ent_t exp_q[$];
  ent_t due_q[$];
  ent_t obs_q[$];

  // Directed vectors: gain, shift, round, x, y -> x_out, y_out, sat_x, sat_y
  logic [31:0] d_gain [9] = '{32'hdbd95b17, 32'hdbd95b17, 32'hdbd95b17, 32'hdbd95b17,
                              32'h80000000, 32'h80000000, 32'h00000000, 32'hffffffff,
                              32'h80000000};
  int d_sh  [9] = '{1, 1, 1, 1, 7, 7, 7, 0, 2};
  int d_rnd [9] = '{0, 1, 0, 1, 0, 1, 1, 1, 0};
  int d_x   [9] = '{1000, 1000, 2047, 2047, 1, 1, 2047, 2047, 1024};
  int d_y   [9] = '{-1000, -1000, -2048, -2048, -1, -1, -2048, -2048, -1025};
  int d_ex  [9] = '{1717, 1718, 2047, 2047, 64, 64, 0, 2047, 2047};
  int d_ey  [9] = '{-1718, -1718, -2048, -2048, -64, -64, 0, -2048, -2048};
  int d_sx  [9] = '{0, 0, 1, 1, 0, 0, 0, 0, 1};
  int d_sy  [9] = '{0, 0, 1, 1, 0, 0, 0, 0, 1};

  gain_shift_saturate #(.IW(IW), .OW(OW), .GW(GW), .SW(SW), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .x_in(x_in), .y_in(y_in),
    .gain(gain), .shift(shift), .round_en(round_en), .sat_clr(sat_clr),
    .out_valid(out_valid), .x_out(x_out), .y_out(y_out), .sat_x(sat_x), .sat_y(sat_y),
    .sat_sticky(sat_sticky), .sat_count(sat_count)
  );

  gain_shift_saturate #(.IW(IW), .OW(OW), .GW(GW), .SW(SW), .CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .x_in(x_in), .y_in(y_in),
    .gain(gain), .shift(shift), .round_en(round_en), .sat_clr(sat_clr),
    .out_valid(out_valid_4), .x_out(x_out_4), .y_out(y_out_4), .sat_x(sat_x_4), .sat_y(sat_y_4),
    .sat_sticky(sat_sticky_4), .sat_count(sat_count_4)
  );

  always #5 clk = ~clk;

  // Reference: value = floor((s * gain * 2^shift + round * 2^31) / 2^32), then clamped
  function automatic void model(input logic signed [IW-1:0] s, input logic [GW-1:0] g,
                                input logic [SW-1:0] sh, input logic rnd,
                                output logic [OW-1:0] o, output logic sat);
    longint p, t, v;
    p = longint'(s) * longint'({32'd0, g});
    t = p << sh;
    if (rnd) t = t + (longint'(1) << 31);
    v = t >>> 32;
    if (v > 2047) begin
      o = 12'h7ff; sat = 1'b1;
    end else if (v < -2048) begin
      o = 12'h800; sat = 1'b1;
    end else begin
      o = v[11:0]; sat = 1'b0;
    end
  endfunction

  // Advance one clock. Record accepted samples with the ce-cycle index at
  // which their result is due, and record what the DUT presents after
  // each ce edge. Also track the expected sticky flag and counters.
  task automatic cycle();
    bit   ce_s, iv_s, clr_s, evt;
    ent_t e, d, o;
    ce_s  = ce;
    iv_s  = in_valid;
    clr_s = sat_clr;
    evt   = 0;
    model(x_in, gain, shift, round_en, e.r.x, e.r.sx);
    model(y_in, gain, shift, round_en, e.r.y, e.r.sy);
    @(posedge clk);
    #1;
    if (ce_s) begin
      ce_cnt++;
      if (iv_s) begin
        e.idx = ce_cnt + 2;
        exp_q.push_back(e);
      end
      if (exp_q.size() > 0 && exp_q[0].idx == ce_cnt) begin
        d = exp_q.pop_front();
        due_q.push_back(d);
        evt = d.r.sx | d.r.sy;
      end
      if (out_valid) begin
        o.r.x = x_out; o.r.y = y_out; o.r.sx = sat_x; o.r.sy = sat_y;
        o.idx = ce_cnt;
        obs_q.push_back(o);
      end
    end
    if (clr_s) begin
      m_cnt16 = 0; m_cnt4 = 0; m_sticky = 0;
    end else if (evt) begin
      m_sticky = 1;
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  task automatic idle(input int n);
    ce = 1'b1; in_valid = 1'b0; sat_clr = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    ce = 1'b1; in_valid = 1'b1; x_in = 12'sd1000; y_in = -12'sd1000;
    gain = 32'hdbd95b17; shift = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_valid_4 !== 1'b0) $display("FAIL reset_valid: got %b/%b want 0", out_valid, out_valid_4);
    else n_pass++;
    n_checks++;
    if (x_out !== 12'sd0 || y_out !== 12'sd0) $display("FAIL reset_data: got %0d/%0d want 0/0", x_out, y_out);
    else n_pass++;
    n_checks++;
    if ({sat_x, sat_y, sat_sticky} !== 3'b000) $display("FAIL reset_flags: got %b%b%b want 000", sat_x, sat_y, sat_sticky);
    else n_pass++;
    n_checks++;
    if (sat_count !== 16'd0 || sat_count_4 !== 4'd0) $display("FAIL reset_count: got %0d/%0d want 0", sat_count, sat_count_4);
    else n_pass++;
    #2 rst = 1'b0;
    in_valid = 1'b0;
    idle(4);
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL reset_no_output: got %0d outputs want 0", obs_q.size());
    else n_pass++;
    obs_q.delete(); due_q.delete(); exp_q.delete();
  endtask

  task automatic test_directed();
    res_t er;
    ce = 1'b1;
    for (int i = 0; i < 9; i++) begin
      gain = d_gain[i]; shift = d_sh[i][2:0]; round_en = d_rnd[i][0];
      x_in = d_x[i][11:0]; y_in = d_y[i][11:0]; in_valid = 1'b1;
      cycle();
    end
    idle(5);
    n_checks++;
    if (obs_q.size() !== 9 || due_q.size() !== 9) $display("FAIL dir_count: got %0d outputs (%0d due) want 9", obs_q.size(), due_q.size());
    else n_pass++;
    for (int i = 0; i < 9 && i < obs_q.size() && i < due_q.size(); i++) begin
      er.x = d_ex[i][11:0]; er.y = d_ey[i][11:0]; er.sx = d_sx[i][0]; er.sy = d_sy[i][0];
      n_checks++;
      if (obs_q[i].r !== er)
        $display("FAIL dir_value[%0d]: got x=%0d y=%0d sat=%b%b want x=%0d y=%0d sat=%b%b",
                 i, obs_q[i].r.x, obs_q[i].r.y, obs_q[i].r.sx, obs_q[i].r.sy, er.x, er.y, er.sx, er.sy);
      else n_pass++;
      n_checks++;
      if (obs_q[i].idx !== due_q[i].idx) $display("FAIL dir_latency[%0d]: got ce-cycle %0d want %0d", i, obs_q[i].idx, due_q[i].idx);
      else n_pass++;
    end
    n_checks++;
    if (sat_count !== 16'd3 || sat_sticky !== 1'b1) $display("FAIL dir_sat_count: got %0d sticky %b want 3 sticky 1", sat_count, sat_sticky);
    else n_pass++;
    obs_q.delete(); due_q.delete();
  endtask

  task automatic test_count_saturate();
    ce = 1'b0; sat_clr = 1'b1; in_valid = 1'b0;
    cycle();
    sat_clr = 1'b0;
    n_checks++;
    if (sat_count !== 16'd0 || sat_count_4 !== 4'd0 || sat_sticky !== 1'b0)
      $display("FAIL clr_ce_low: got %0d/%0d sticky %b want 0/0 sticky 0", sat_count, sat_count_4, sat_sticky);
    else n_pass++;
    ce = 1'b1; gain = 32'hffffffff; shift = 3'd7; round_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      x_in = 12'sd2047; y_in = 12'($urandom_range(0, 7)); in_valid = 1'b1;
      cycle();
    end
    idle(5);
    n_checks++;
    if (sat_count_4 !== 4'd15) $display("FAIL cnt4_saturate: got %0d want 15", sat_count_4);
    else n_pass++;
    n_checks++;
    if (sat_count !== 16'd20 || sat_sticky_4 !== 1'b1) $display("FAIL cnt16_events: got %0d sticky4 %b want 20 sticky4 1", sat_count, sat_sticky_4);
    else n_pass++;
    obs_q.delete(); due_q.delete();
  endtask

  task automatic test_sat_clr_collision();
    ce = 1'b1; gain = 32'hffffffff; shift = 3'd7; round_en = 1'b1;
    x_in = -12'sd2048; y_in = 12'sd0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    sat_clr = 1'b1;
    cycle();
    sat_clr = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || sat_x !== 1'b1 || x_out !== -12'sd2048)
      $display("FAIL clr_collision_out: got valid %b sat_x %b x %0d want 1 1 -2048", out_valid, sat_x, x_out);
    else n_pass++;
    n_checks++;
    if (sat_count !== 16'd0 || sat_sticky !== 1'b0) $display("FAIL clr_collision_status: got %0d sticky %b want 0 sticky 0", sat_count, sat_sticky);
    else n_pass++;
    cycle();
    n_checks++;
    if (sat_count !== 16'd0 || sat_count_4 !== 4'd0) $display("FAIL clr_event_dropped: got %0d/%0d want 0/0", sat_count, sat_count_4);
    else n_pass++;
    idle(3);
    obs_q.delete(); due_q.delete();
  endtask

  task automatic test_random_ce();
    for (int k = 0; k < 240; k++) begin
      ce       = ($urandom_range(0, 9) < 7);
      in_valid = (k % 2 == 0);
      x_in     = 12'($urandom_range(0, 4095));
      y_in     = 12'($urandom_range(0, 4095));
      gain     = $urandom;
      shift    = 3'($urandom_range(0, 7));
      round_en = 1'($urandom_range(0, 1));
      sat_clr  = (k == 120);
      cycle();
      n_checks++;
      if (!out_valid && (sat_x || sat_y)) $display("FAIL rnd_bubble_flags[%0d]: got sat %b%b with out_valid 0 want 00", k, sat_x, sat_y);
      else n_pass++;
    end
    idle(5);
    n_checks++;
    if (obs_q.size() !== due_q.size()) $display("FAIL rnd_count: got %0d outputs want %0d", obs_q.size(), due_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < due_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].r !== due_q[i].r || obs_q[i].idx !== due_q[i].idx)
        $display("FAIL rnd_sample[%0d]: got x=%0d y=%0d sat=%b%b @%0d want x=%0d y=%0d sat=%b%b @%0d",
                 i, obs_q[i].r.x, obs_q[i].r.y, obs_q[i].r.sx, obs_q[i].r.sy, obs_q[i].idx,
                 due_q[i].r.x, due_q[i].r.y, due_q[i].r.sx, due_q[i].r.sy, due_q[i].idx);
      else n_pass++;
    end
    n_checks++;
    if (sat_count !== 16'(m_cnt16) || sat_count_4 !== 4'(m_cnt4) || sat_sticky !== m_sticky)
      $display("FAIL rnd_status: got %0d/%0d sticky %b want %0d/%0d sticky %b", sat_count, sat_count_4, sat_sticky, m_cnt16, m_cnt4, m_sticky);
    else n_pass++;
    obs_q.delete(); due_q.delete();
  endtask

  task automatic test_back_to_back();
    ce = 1'b1; sat_clr = 1'b1; in_valid = 1'b0;
    cycle();
    sat_clr = 1'b0;
    for (int k = 0; k < 60; k++) begin
      in_valid = 1'b1;
      x_in     = 12'($urandom_range(0, 4095));
      y_in     = 12'($urandom_range(0, 4095));
      gain     = (k % 3 == 0) ? 32'hdbd95b17 : $urandom;
      shift    = 3'($urandom_range(0, 7));
      round_en = 1'($urandom_range(0, 1));
      cycle();
    end
    idle(5);
    n_checks++;
    if (obs_q.size() !== 60 || due_q.size() !== 60) $display("FAIL b2b_count: got %0d outputs (%0d due) want 60", obs_q.size(), due_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < due_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].r !== due_q[i].r || obs_q[i].idx !== due_q[i].idx)
        $display("FAIL b2b_sample[%0d]: got x=%0d y=%0d sat=%b%b @%0d want x=%0d y=%0d sat=%b%b @%0d",
                 i, obs_q[i].r.x, obs_q[i].r.y, obs_q[i].r.sx, obs_q[i].r.sy, obs_q[i].idx,
                 due_q[i].r.x, due_q[i].r.y, due_q[i].r.sx, due_q[i].r.sy, due_q[i].idx);
      else n_pass++;
    end
    n_checks++;
    if (sat_count !== 16'(m_cnt16) || sat_count_4 !== 4'(m_cnt4) || sat_sticky_4 !== m_sticky)
      $display("FAIL b2b_status: got %0d/%0d sticky %b want %0d/%0d sticky %b", sat_count, sat_count_4, sat_sticky_4, m_cnt16, m_cnt4, m_sticky);
    else n_pass++;
    obs_q.delete(); due_q.delete();
  endtask

  task automatic test_reset_midstream();
    int n;
    ce = 1'b1; gain = 32'hdbd95b17; shift = 3'd1; round_en = 1'b0;
    x_in = 12'sd1000; y_in = -12'sd1000; in_valid = 1'b1;
    repeat (3) cycle();
    n_checks++;
    if (out_valid !== 1'b1 || x_out !== 12'sd1717) $display("FAIL mid_pre_reset: got valid %b x %0d want 1 1717", out_valid, x_out);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || x_out !== 12'sd0 || y_out !== 12'sd0 || sat_x !== 1'b0 || sat_y !== 1'b0)
      $display("FAIL mid_reset_outputs: got valid %b x %0d y %0d sat %b%b want all 0", out_valid, x_out, y_out, sat_x, sat_y);
    else n_pass++;
    n_checks++;
    if (sat_count !== 16'd0 || sat_sticky !== 1'b0) $display("FAIL mid_reset_status: got %0d sticky %b want 0 sticky 0", sat_count, sat_sticky);
    else n_pass++;
    exp_q.delete(); due_q.delete(); obs_q.delete();
    m_cnt16 = 0; m_cnt4 = 0; m_sticky = 0;
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    x_in = 12'sd1000; y_in = -12'sd1000; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 8) begin
      cycle();
      n++;
    end
    n_checks++;
    if (n !== 3) $display("FAIL mid_latency: got %0d ce-cycles want 3", n);
    else n_pass++;
    n_checks++;
    if (x_out !== 12'sd1717 || y_out !== -12'sd1718) $display("FAIL mid_first_sample: got %0d/%0d want 1717/-1718", x_out, y_out);
    else n_pass++;
    idle(4);
    n_checks++;
    if (obs_q.size() !== 1) $display("FAIL mid_discarded: got %0d outputs want 1", obs_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_count_saturate();
    test_sat_clr_collision();
    test_random_ce();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
